ram_access_arbiter: RTL

- Shares one single-port embedded RAM (256 x 8 by default) between NUM_REQ independent datapath requesters.
- Typical requesters: a fill engine, a compute engine and a readback/LED engine.
- Grants whole bursts round-robin and muxes the owner's address, data and write-enable onto the RAM port.
- Returns read data tagged to the requester that issued the read; forcibly reclaims the RAM from an owner that holds it too long.

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/rd_tag_pipe.sv | 16 +
 rtl/ram_access_arbiter.sv | 95 +++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types, default widths and round-robin pick for the RAM arbiter
package ram_arb_pkg;
  typedef enum logic {ARB, BUSY} state_e;
  localparam int DEF_NUM_REQ = 3;
  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int MAX_REQ = 8;
  // First requesting index at or after ptr, modulo n; lowest offset wins
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req, input logic [2:0] ptr, input int n);
    logic [2:0] w;
    logic [2:0] idx;
    w = ptr;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      idx = 3'((int'(ptr) + i) % n);
      if (i < n && req[idx]) w = idx;
    end
    return w;
  endfunction
endpackage

// File: rtl/rd_tag_pipe.sv
// rd_tag_pipe: DEPTH-stage shift register of one-hot read tags with synchronous clear
module rd_tag_pipe #(
  parameter int DEPTH = 1,
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] tag_i,
  output logic [W-1:0] tag_o
);
  localparam int SW = DEPTH * W;
  logic [SW-1:0] sr_q;
  always_ff @(posedge clk_i)
    sr_q <= rst_i ? '0 : SW'({sr_q, tag_i});
  assign tag_o = sr_q[SW-1 -: W];
endmodule

// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: round-robin burst arbiter sharing one single-port RAM among
// NUM_REQ requesters, with tagged read return and forced release after MAX_HOLD cycles
module ram_access_arbiter
  import ram_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LATENCY = 1,
  parameter int MAX_HOLD = 64
) (
  input  logic                      CLOCK_50_I,
  input  logic                      RESET_I,
  input  logic [NUM_REQ-1:0]        REQ_I,
  input  logic [NUM_REQ-1:0]        LAST_I,
  input  logic [NUM_REQ-1:0]        WE_I,
  input  logic [NUM_REQ*ADDR_W-1:0] ADDR_I,
  input  logic [NUM_REQ*DATA_W-1:0] WDATA_I,
  output logic [NUM_REQ-1:0]        GNT_O,
  output logic [NUM_REQ-1:0]        RVALID_O,
  output logic [DATA_W-1:0]         RDATA_O,
  output logic                      TIMEOUT_O,
  output logic [ADDR_W-1:0]         RAM_ADDR_O,
  output logic [DATA_W-1:0]         RAM_WDATA_O,
  output logic                      RAM_WE_O,
  input  logic [DATA_W-1:0]         RAM_RDATA_I
);
  localparam int PW = $clog2(NUM_REQ);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD - 1);
  state_e state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic timeout_q, timeout_d;
  logic [2:0] win;
  logic acc_last;
  assign win = rr_pick(MAX_REQ'(REQ_I), 3'(ptr_q), NUM_REQ);
  assign acc_last = |(gnt_q & REQ_I & LAST_I);
  assign RAM_WE_O = |(gnt_q & REQ_I & WE_I);
  assign GNT_O = gnt_q;
  assign TIMEOUT_O = timeout_q;
  assign RDATA_O = RAM_RDATA_I;
  // AND-OR mux on the one-hot grant; idle grant drives zeros
  always_comb begin
    RAM_ADDR_O = '0;
    RAM_WDATA_O = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      RAM_ADDR_O = RAM_ADDR_O | ({ADDR_W{gnt_q[i]}} & ADDR_I[i*ADDR_W +: ADDR_W]);
      RAM_WDATA_O = RAM_WDATA_O | ({DATA_W{gnt_q[i]}} & WDATA_I[i*DATA_W +: DATA_W]);
    end
  end
  always_comb begin
    state_d = state_q;
    gnt_d = gnt_q;
    ptr_d = ptr_q;
    hold_d = hold_q;
    timeout_d = 1'b0;
    if (state_q == ARB) begin
      if (|REQ_I) begin
        state_d = BUSY;
        gnt_d = NUM_REQ'(1) << win;
        ptr_d = (int'(win) == NUM_REQ - 1) ? '0 : PW'(win + 3'd1);
        hold_d = '0;
      end
    end else if (acc_last || hold_q == HOLD_LIM) begin
      state_d = ARB;
      gnt_d = '0;
      timeout_d = !acc_last;
    end else begin
      hold_d = hold_q + 1'b1;
    end
  end
  always_ff @(posedge CLOCK_50_I) begin
    if (RESET_I) begin
      state_q <= ARB;
      gnt_q <= '0;
      ptr_q <= '0;
      hold_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q <= gnt_d;
      ptr_q <= ptr_d;
      hold_q <= hold_d;
      timeout_q <= timeout_d;
    end
  end
  rd_tag_pipe #(.DEPTH(RD_LATENCY), .W(NUM_REQ)) u_tag (
    .clk_i(CLOCK_50_I),
    .rst_i(RESET_I),
    .tag_i(gnt_q & REQ_I & ~WE_I),
    .tag_o(RVALID_O)
  );
endmodule
